operand_fetch: RTL and testbench

Operand-fetch stage sitting between instruction fetch and execute, wrapped around the 32×32 three-port `regfile`. It drives `ra1`/`ra2` from the incoming instruction and captures `rd1`/`rd2` into a one-entry pipeline register with valid/ready handshakes. A destination-register scoreboard stalls on RAW/WAW hazards until writeback. The regfile write port is bypassed so a value written this cycle is captured correctly.

---
 rtl/operand_fetch_pkg.sv | 31 +++
 rtl/operand_fetch_if.sv | 33 +++
 rtl/operand_fetch_scoreboard.sv | 48 ++++
 rtl/operand_fetch.sv | 109 ++++++++++
 tb/tb_operand_fetch.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared types, sizes and RV32I decode helpers for the operand-fetch stage.
package opfetch_pkg;

   localparam int XLEN = 32;
   localparam int NREG = 32;

   typedef logic [4:0] regaddr_t;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   // Every format except U-type and JAL reads rs1.
   function automatic logic uses_rs1(input logic [6:0] opcode);
      return !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
   endfunction

   // Only R-type, stores and branches read rs2.
   function automatic logic uses_rs2(input logic [6:0] opcode);
      return (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
   endfunction

   // Stores and branches have no destination; x0 is never tracked.
   function automatic logic writes_rd(input logic [6:0] opcode, input regaddr_t rd);
      return !((opcode == OPC_STORE) || (opcode == OPC_BRANCH)) && (rd != 5'd0);
   endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Fetch-side and execute-side handshakes of the operand-fetch stage.
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high; the sender keeps valid and its payload stable
// until that edge, and ready may depend combinationally on the payload.
interface operand_fetch_if;
   import opfetch_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [XLEN-1:0]  in_instr;
   logic [XLEN-1:0]  in_pc;

   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_instr;
   logic [XLEN-1:0]  out_pc;
   logic [XLEN-1:0]  out_op1;
   logic [XLEN-1:0]  out_op2;
   regaddr_t         out_rd;

   // Environment side: fetch producer and execute consumer.
   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_instr, out_pc, out_op1, out_op2, out_rd
   );

   // The operand-fetch stage itself.
   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_instr, out_pc, out_op1, out_op2, out_rd
   );

endinterface

// File: rtl/operand_fetch_scoreboard.sv
// Destination-register busy tracker. Bit 0 (x0) is never stored.
// busy_eff already discounts this cycle's writeback so a dependent can issue
// in the writeback cycle. A set in the same cycle as a clear wins.
module reg_scoreboard
   import opfetch_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            set_en,
   input  regaddr_t        set_addr,
   input  logic            clr_en,
   input  regaddr_t        clr_addr,
   input  logic            flush_clr_en,
   input  regaddr_t        flush_clr_addr,
   output logic [NREG-1:0] busy,
   output logic [NREG-1:0] busy_eff
);

   logic [NREG-1:1] busy_q;
   logic [NREG-1:1] set_mask;
   logic [NREG-1:1] clr_mask;
   logic [NREG-1:1] fclr_mask;

   // Decode the three ports into one-hot masks; address 0 never touches state.
   always_comb begin
      set_mask  = '0;
      clr_mask  = '0;
      fclr_mask = '0;
      if (set_en && (set_addr != 5'd0))
         set_mask[set_addr] = 1'b1;
      if (clr_en && (clr_addr != 5'd0))
         clr_mask[clr_addr] = 1'b1;
      if (flush_clr_en && (flush_clr_addr != 5'd0))
         fclr_mask[flush_clr_addr] = 1'b1;
   end

   assign busy     = {busy_q, 1'b0};
   assign busy_eff = {busy_q & ~clr_mask, 1'b0};

   // Busy state: clears first, then sets so that a same-cycle set survives.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         busy_q <= '0;
      else
         busy_q <= (busy_q & ~clr_mask & ~fclr_mask) | set_mask;
   end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads rs1/rs2 from the regfile, bypasses the regfile
// write port, stalls on RAW/WAW hazards against in-flight writers, and holds
// the result in a one-entry valid/ready pipeline register.
module operand_fetch
   import opfetch_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   operand_fetch_if.slave  bus,
   output regaddr_t        ra1,
   output regaddr_t        ra2,
   input  logic [XLEN-1:0] rd1,
   input  logic [XLEN-1:0] rd2,
   input  logic            wb_we,
   input  regaddr_t        wb_wa,
   input  logic [XLEN-1:0] wb_wd,
   input  logic            flush,
   output logic [NREG-1:0] busy
);

   logic [6:0]      opcode;
   regaddr_t        rs1;
   regaddr_t        rs2;
   regaddr_t        rd;
   logic            need_rs1;
   logic            need_rs2;
   logic            dest_en;
   logic            clr;
   logic            hazard;
   logic            ready;
   logic            accept;
   logic            flush_clr;
   logic [XLEN-1:0] op1_sel;
   logic [XLEN-1:0] op2_sel;
   logic [NREG-1:0] busy_eff;

   assign opcode = bus.in_instr[6:0];
   assign rd     = bus.in_instr[11:7];
   assign rs1    = bus.in_instr[19:15];
   assign rs2    = bus.in_instr[24:20];
   assign ra1    = rs1;
   assign ra2    = rs2;

   assign clr       = wb_we && (wb_wa != 5'd0);
   assign flush_clr = flush && bus.out_valid && (bus.out_rd != 5'd0);

   reg_scoreboard u_scoreboard (
      .clk            (clk),
      .reset          (reset),
      .set_en         (accept && dest_en),
      .set_addr       (rd),
      .clr_en         (clr),
      .clr_addr       (wb_wa),
      .flush_clr_en   (flush_clr),
      .flush_clr_addr (bus.out_rd),
      .busy           (busy),
      .busy_eff       (busy_eff)
   );

   // Decode, hazard check, input handshake and bypassed operand selection.
   always_comb begin
      need_rs1 = uses_rs1(opcode);
      need_rs2 = uses_rs2(opcode);
      dest_en  = writes_rd(opcode, rd);
      hazard   = (need_rs1 && busy_eff[rs1]) ||
                 (need_rs2 && busy_eff[rs2]) ||
                 (dest_en  && busy_eff[rd]);
      ready    = !flush && !hazard && (!bus.out_valid || bus.out_ready);
      accept   = bus.in_valid && ready;

      op1_sel = rd1;
      if (rs1 == 5'd0)
         op1_sel = '0;
      else if (clr && (wb_wa == rs1))
         op1_sel = wb_wd;

      op2_sel = rd2;
      if (rs2 == 5'd0)
         op2_sel = '0;
      else if (clr && (wb_wa == rs2))
         op2_sel = wb_wd;
   end

   assign bus.in_ready = ready;

   // Pipeline register: flush kills, accept loads, a drain without refill empties.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.out_valid <= 1'b0;
         bus.out_instr <= '0;
         bus.out_pc    <= '0;
         bus.out_op1   <= '0;
         bus.out_op2   <= '0;
         bus.out_rd    <= '0;
      end else if (flush) begin
         bus.out_valid <= 1'b0;
      end else if (accept) begin
         bus.out_valid <= 1'b1;
         bus.out_instr <= bus.in_instr;
         bus.out_pc    <= bus.in_pc;
         bus.out_op1   <= op1_sel;
         bus.out_op2   <= op2_sel;
         bus.out_rd    <= dest_en ? rd : 5'd0;
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios followed by random traffic,
// checked against a transaction-level model of the stage and its regfile.
module tb_operand_fetch;
   import opfetch_pkg::*;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [4:0]  rd;
   } exp_t;

   // ---------------- clock / reset / DUT ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   operand_fetch_if bus ();
   regaddr_t    ra1, ra2;
   logic [31:0] rd1, rd2;
   logic        wb_we;
   regaddr_t    wb_wa;
   logic [31:0] wb_wd;
   logic        flush;
   logic [31:0] busy;

   operand_fetch dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave),
      .ra1   (ra1),
      .ra2   (ra2),
      .rd1   (rd1),
      .rd2   (rd2),
      .wb_we (wb_we),
      .wb_wa (wb_wa),
      .wb_wd (wb_wd),
      .flush (flush),
      .busy  (busy)
   );

   // Reference regfile feeding the combinational read ports.
   logic [31:0] regs [32];
   logic        force_rd;
   assign rd1 = force_rd ? 32'hFFFF_FFFF : regs[ra1];
   assign rd2 = force_rd ? 32'hFFFF_FFFF : regs[ra2];

   // ---------------- model state and scoreboard ----------------
   exp_t        exp_q [$];
   int          pend_q [$];
   bit          busy_m [32];
   bit          valid_m;
   logic [4:0]  held_rd;
   bit          last_acc;
   int          n_cmp = 0;
   int          n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit m_uses_rs1(input logic [6:0] o);
      return !(o inside {7'h37, 7'h17, 7'h6f});
   endfunction

   function automatic bit m_uses_rs2(input logic [6:0] o);
      return o inside {7'h33, 7'h23, 7'h63};
   endfunction

   function automatic bit m_writes_rd(input logic [31:0] ins);
      return !(ins[6:0] inside {7'h23, 7'h63}) && (ins[11:7] != 5'd0);
   endfunction

   function automatic logic [31:0] model_busy();
      logic [31:0] v;
      for (int i = 0; i < 32; i++) v[i] = busy_m[i];
      return v;
   endfunction

   function automatic logic [31:0] i_addi(input int rd, input int rs1, input int imm);
      logic [11:0] im;
      im = imm[11:0];
      return {im, rs1[4:0], 3'b000, rd[4:0], 7'h13};
   endfunction

   function automatic logic [31:0] r_add(input int rd, input int rs1, input int rs2);
      return {7'h00, rs2[4:0], rs1[4:0], 3'b000, rd[4:0], 7'h33};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [6:0] opcs [8];
      logic [31:0] ins;
      opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h23, 7'h63, 7'h03};
      ins = $urandom;
      ins[6:0]   = opcs[$urandom_range(0, 7)];
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      return ins;
   endfunction

   function automatic logic [31:0] operand(input logic [4:0] r, input bit c,
                                           input logic [4:0] wa, input logic [31:0] wd);
      if (r == 5'd0) return 32'h0;
      if (c && (wa == r)) return wd;
      return force_rd ? 32'hFFFF_FFFF : regs[r];
   endfunction

   // One clock of the model: check at negedge, predict, update after posedge.
   task automatic step();
      logic [31:0] ins;
      logic [4:0]  s1, s2, d, wa;
      logic [31:0] wd;
      bit c, hz, rdy, acc, fl, ordy, wr;
      exp_t e;
      @(negedge clk);
      ins  = bus.in_instr;
      s1   = ins[19:15];
      s2   = ins[24:20];
      d    = ins[11:7];
      wa   = wb_wa;
      wd   = wb_wd;
      c    = wb_we && (wb_wa != 5'd0);
      fl   = flush;
      ordy = bus.out_ready;
      wr   = m_writes_rd(ins);
      hz   = (m_uses_rs1(ins[6:0]) && busy_m[s1] && !(c && wa == s1)) ||
             (m_uses_rs2(ins[6:0]) && busy_m[s2] && !(c && wa == s2)) ||
             (wr && busy_m[d] && !(c && wa == d));
      rdy  = !fl && !hz && (!valid_m || ordy);
      chk("in_ready", {31'b0, bus.in_ready}, {31'b0, rdy});
      chk("out_valid", {31'b0, bus.out_valid}, {31'b0, valid_m});
      chk("busy", busy, model_busy());
      acc = bus.in_valid && rdy;
      if (acc) begin
         e.instr = ins;
         e.pc    = bus.in_pc;
         e.op1   = operand(s1, c, wa, wd);
         e.op2   = operand(s2, c, wa, wd);
         e.rd    = wr ? d : 5'd0;
         exp_q.push_back(e);
      end
      if (fl && valid_m && exp_q.size() > 0) void'(exp_q.pop_front());
      @(posedge clk);
      #1;
      if (wb_we && wa != 5'd0) begin
         regs[wa]   = wd;
         busy_m[wa] = 1'b0;
         for (int i = pend_q.size() - 1; i >= 0; i--)
            if (pend_q[i] == int'(wa)) pend_q.delete(i);
      end
      if (fl && valid_m && held_rd != 5'd0) busy_m[held_rd] = 1'b0;
      if (valid_m && ordy && !fl && held_rd != 5'd0) pend_q.push_back(int'(held_rd));
      if (fl) valid_m = 1'b0;
      else if (acc) valid_m = 1'b1;
      else if (ordy) valid_m = 1'b0;
      if (acc) begin
         held_rd = wr ? d : 5'd0;
         if (wr) busy_m[d] = 1'b1;
      end
      last_acc = acc;
   endtask

   // Retire everything in flight so the next scenario starts hazard-free.
   task automatic drain();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      flush         = 1'b0;
      wb_we         = 1'b0;
      step();
      for (int k = 0; k < 40 && pend_q.size() > 0; k++) begin
         wb_we = 1'b1;
         wb_wa = 5'(pend_q[0]);
         wb_wd = $urandom;
         step();
      end
      wb_we = 1'b0;
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
      valid_m = 1'b0;
      held_rd = 5'd0;
      exp_q.delete();
      pend_q.delete();
   endfunction

   // Monitor: pops the expected entry whenever execute takes an instruction.
   always @(negedge clk) begin
      exp_t e;
      if (!reset && bus.out_valid && bus.out_ready && !flush) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL out_unexpected: got instr %h with no expected entry", bus.out_instr);
         end else begin
            e = exp_q.pop_front();
            chk("out_instr", bus.out_instr, e.instr);
            chk("out_pc", bus.out_pc, e.pc);
            chk("out_op1", bus.out_op1, e.op1);
            chk("out_op2", bus.out_op2, e.op2);
            chk("out_rd", {27'b0, bus.out_rd}, {27'b0, e.rd});
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] pc;
      for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'h0 : $urandom;
      regs[2]       = 32'h0;
      force_rd      = 1'b0;
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_instr  = 32'h0;
      bus.in_pc     = 32'h0;
      bus.out_ready = 1'b0;
      wb_we = 1'b0; wb_wa = 5'd0; wb_wd = 32'h0; flush = 1'b0;
      model_reset();
      last_acc = 1'b0;
      pc = 32'h1000;

      // Reset state.
      #12;
      chk("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
      chk("rst_busy", busy, 32'h0);
      chk("rst_out_instr", bus.out_instr, 32'h0);
      chk("rst_out_op1", bus.out_op1, 32'h0);
      chk("rst_out_rd", {27'b0, bus.out_rd}, 32'h0);
      chk("rst_in_ready", {31'b0, bus.in_ready}, 32'h1);
      @(posedge clk); #1;
      reset = 1'b0;

      // Back-to-back issue.
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_instr  = i_addi(1, 0, 5); bus.in_pc = 32'h100;
      step();
      bus.in_instr  = i_addi(2, 0, 7); bus.in_pc = 32'h104;
      step();
      chk("b2b_busy", busy, 32'h6);
      drain();

      // RAW stall released by the writeback bypass.
      bus.in_valid = 1'b1;
      bus.in_instr = i_addi(2, 0, 'h15); bus.in_pc = 32'h200;
      step();
      bus.in_instr = r_add(3, 2, 2); bus.in_pc = 32'h204;
      step();
      step();
      chk("raw_stalled", {31'b0, last_acc}, 32'h0);
      wb_we = 1'b1; wb_wa = 5'd2; wb_wd = 32'h15;
      step();
      wb_we = 1'b0;
      chk("raw_op1", bus.out_op1, 32'h15);
      chk("raw_op2", bus.out_op2, 32'h15);
      drain();

      // x0 operands ignore both the regfile and a write to x0.
      force_rd = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_instr = r_add(5, 0, 0); bus.in_pc = 32'h300;
      wb_we = 1'b1; wb_wa = 5'd0; wb_wd = 32'hDEAD_BEEF;
      step();
      force_rd = 1'b0;
      wb_we = 1'b0;
      chk("x0_op1", bus.out_op1, 32'h0);
      chk("x0_busy0", {31'b0, busy[0]}, 32'h0);
      drain();

      // Backpressure: held entry stays frozen, then a waiting instruction enters.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_instr  = i_addi(7, 0, 1); bus.in_pc = 32'h400;
      step();
      bus.in_instr  = r_add(9, 1, 3); bus.in_pc = 32'h404;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("bp_hold_instr", bus.out_instr, exp_q[0].instr);
         chk("bp_hold_op1", bus.out_op1, exp_q[0].op1);
      end
      bus.out_ready = 1'b1;
      step();
      chk("bp_release_acc", {31'b0, last_acc}, 32'h1);
      drain();

      // Flush kills the held instruction and its busy bit; nothing is captured.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_instr  = i_addi(4, 0, 3); bus.in_pc = 32'h500;
      step();
      flush = 1'b1;
      bus.in_instr = i_addi(10, 0, 9); bus.in_pc = 32'h504;
      step();
      flush = 1'b0;
      bus.in_valid = 1'b0;
      chk("flush_valid", {31'b0, bus.out_valid}, 32'h0);
      chk("flush_busy4", {31'b0, busy[4]}, 32'h0);
      chk("flush_busy10", {31'b0, busy[10]}, 32'h0);
      drain();

      // Set and clear of x6 in the same cycle: set wins.
      bus.in_valid = 1'b1;
      bus.in_instr = i_addi(6, 0, 1); bus.in_pc = 32'h600;
      step();
      bus.in_valid = 1'b0;
      step();
      bus.in_valid = 1'b1;
      bus.in_instr = i_addi(6, 0, 2); bus.in_pc = 32'h604;
      wb_we = 1'b1; wb_wa = 5'd6; wb_wd = 32'h66;
      step();
      wb_we = 1'b0;
      bus.in_valid = 1'b0;
      chk("collide_busy6", {31'b0, busy[6]}, 32'h1);

      // Asynchronous reset while an instruction is held.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_instr  = i_addi(11, 0, 4); bus.in_pc = 32'h700;
      step();
      bus.in_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_valid", {31'b0, bus.out_valid}, 32'h0);
      chk("async_rst_busy", busy, 32'h0);
      model_reset();
      @(posedge clk); #1;
      reset = 1'b0;

      // Random traffic.
      for (int n = 0; n < 1500; n++) begin
         if (!(bus.in_valid && !last_acc)) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_instr = rand_instr();
            bus.in_pc    = pc;
            pc           = pc + 4;
         end
         bus.out_ready = ($urandom_range(0, 3) != 0);
         flush         = ($urandom_range(0, 19) == 0);
         wb_we = 1'b0;
         wb_wa = 5'($urandom_range(0, 31));
         wb_wd = $urandom;
         if (pend_q.size() > 0 && $urandom_range(0, 2) == 0) begin
            wb_we = 1'b1;
            wb_wa = 5'(pend_q[$urandom_range(0, pend_q.size() - 1)]);
         end else if ($urandom_range(0, 7) == 0) begin
            wb_wa = 5'($urandom_range(0, 7));
            wb_we = !busy_m[wb_wa];
         end
         step();
      end
      drain();
      chk("end_queue_empty", exp_q.size(), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
